inst_fetch_seq: RTL and testbench



---
 rtl/inst_fetch_seq.sv | 77 +++++++
 tb/tb_inst_fetch_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_seq.sv
// inst_fetch_seq: single-issue MIPS fetch sequencer (imem req/ack, decode valid/ready, PC resolve)
module inst_fetch_seq #(
    parameter int          PC_W     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP  = 6'b111111
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     inst_out,
    output logic            inst_valid,
    input  logic            inst_ready,
    input  logic            resolve,
    input  logic            jump,
    input  logic            branch,
    input  logic            zero,
    output logic [PC_W-1:0] pc_out,
    output logic            halted
);
    typedef enum logic [2:0] {FETCH, WAIT_ACK, ISSUE, RESOLVE, HALT} state_t;
    state_t state, state_n;
    logic [PC_W-1:0] pc, pc_n, pc_plus4, jmp_tgt, br_tgt;
    logic [31:0] inst_n;
    logic valid_n, req_n;
    assign pc_plus4  = pc + 32'd4;
    assign jmp_tgt   = {pc_plus4[31:28], inst_out[25:0], 2'b00};
    assign br_tgt    = pc_plus4 + {{14{inst_out[15]}}, inst_out[15:0], 2'b00};
    assign imem_addr = pc;
    assign pc_out    = pc;
    assign halted    = state == HALT;
    always_comb begin
        state_n = state;
        pc_n    = pc;
        inst_n  = inst_out;
        valid_n = inst_valid;
        req_n   = imem_req;
        case (state)
            FETCH: begin
                req_n   = 1'b1;
                state_n = WAIT_ACK;
            end
            WAIT_ACK: if (imem_ack) begin
                inst_n  = imem_rdata;
                req_n   = 1'b0;
                valid_n = 1'b1;
                state_n = ISSUE;
            end
            ISSUE: if (inst_valid && inst_ready) begin
                valid_n = 1'b0;
                state_n = inst_out[31:26] == HALT_OP ? HALT : RESOLVE;
            end
            RESOLVE: if (resolve) begin
                pc_n    = jump ? jmp_tgt : (branch && zero) ? br_tgt : pc_plus4;
                state_n = FETCH;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            inst_out   <= '0;
            inst_valid <= 1'b0;
            imem_req   <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            inst_out   <= inst_n;
            inst_valid <= valid_n;
            imem_req   <= req_n;
        end
    end
endmodule

// File: tb/tb_inst_fetch_seq.sv
// tb_inst_fetch_seq: table-driven directed checks of the fetch/issue/resolve loop plus reset and halt corners
module tb_inst_fetch_seq;
    logic        clk = 1'b0;
    logic        reset, imem_req, imem_ack, inst_valid, inst_ready;
    logic        resolve, jump, branch, zero, halted;
    logic [31:0] imem_addr, imem_rdata, inst_out, pc_out;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        int          ack_dly;
        int          rdy_dly;
        logic        j;
        logic        b;
        logic        z;
        logic [31:0] next;
        logic        halt;
    } vec_t;
    vec_t vecs[10];

    inst_fetch_seq dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_out(inst_out),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .resolve(resolve),
        .jump(jump), .branch(branch), .zero(zero), .pc_out(pc_out), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_req(input logic [31:0] addr);
        int n = 0;
        while (imem_req !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("req_rise", {31'd0, imem_req}, 32'd1);
        chk("req_addr", imem_addr, addr);
        chk("pc_out", pc_out, addr);
    endtask

    task automatic run_vec(input vec_t v);
        wait_req(v.pc);
        for (int i = 0; i < v.ack_dly; i++) begin
            @(negedge clk);
            chk("req_hold", {31'd0, imem_req}, 32'd1);
            chk("addr_hold", imem_addr, v.pc);
        end
        imem_ack = 1'b1;
        imem_rdata = v.inst;
        @(negedge clk);
        imem_rdata = $urandom;
        chk("issue_valid", {31'd0, inst_valid}, 32'd1);
        chk("issue_inst", inst_out, v.inst);
        chk("req_drop", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < v.rdy_dly; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, inst_valid}, 32'd1);
            chk("stall_inst", inst_out, v.inst);
            chk("stall_noreq", {31'd0, imem_req}, 32'd0);
        end
        imem_ack = 1'b0;
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        chk("accept_clear", {31'd0, inst_valid}, 32'd0);
        chk("inst_keep", inst_out, v.inst);
        if (v.halt) begin
            chk("halted", {31'd0, halted}, 32'd1);
            for (int i = 0; i < 20; i++) begin
                resolve = (i == 3);
                jump = (i == 3);
                imem_ack = (i == 5);
                inst_ready = (i == 7);
                @(negedge clk);
                chk("halt_noreq", {31'd0, imem_req}, 32'd0);
                chk("halt_stay", {31'd0, halted}, 32'd1);
            end
            {resolve, jump, imem_ack, inst_ready} = '0;
        end else begin
            {jump, branch, zero} = 3'b111;
            @(negedge clk);
            chk("no_resolve_pc", pc_out, v.pc);
            chk("no_resolve_req", {31'd0, imem_req}, 32'd0);
            {jump, branch, zero} = {v.j, v.b, v.z};
            resolve = 1'b1;
            @(negedge clk);
            {resolve, jump, branch, zero} = '0;
            chk("next_pc", pc_out, v.next);
        end
    endtask

    initial begin
        {imem_ack, inst_ready, resolve, jump, branch, zero} = '0;
        imem_rdata = 32'h0;
        reset = 1'b1;
        vecs[0] = '{32'h0000_0000, 32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0004, 1'b0};
        vecs[1] = '{32'h0000_0004, 32'h0800_0010, 0, 0, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 1'b0};
        vecs[2] = '{32'h0000_0040, 32'h0800_0010, 0, 1, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 1'b0};
        vecs[3] = '{32'h0000_0040, 32'h1000_0003, 1, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0050, 1'b0};
        vecs[4] = '{32'h0000_0050, 32'h1000_FFFF, 0, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0050, 1'b0};
        vecs[5] = '{32'h0000_0050, 32'h1000_0003, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0054, 1'b0};
        vecs[6] = '{32'h0000_0054, 32'h0000_0020, 3, 4, 1'b0, 1'b0, 1'b0, 32'h0000_0058, 1'b0};
        vecs[7] = '{32'h0000_0058, 32'h1000_FFE8, 0, 0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0};
        vecs[8] = '{32'hFFFF_FFFC, 32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
        vecs[9] = '{32'h0000_0000, 32'hFC00_0000, 0, 2, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
        repeat (2) @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst_out, 32'd0);
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("req_one_cycle", {31'd0, imem_req}, 32'd1);
        for (int k = 0; k < 10; k++) run_vec(vecs[k]);
        // only reset leaves HALT
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("halt_exit", {31'd0, halted}, 32'd0);
        run_vec(vecs[1 - 1]);
        wait_req(32'h0000_0004);
        // reset during WAIT_ACK, colliding with an ack
        reset = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        reset = 1'b0;
        imem_ack = 1'b0;
        chk("rwa_req", {31'd0, imem_req}, 32'd0);
        chk("rwa_valid", {31'd0, inst_valid}, 32'd0);
        chk("rwa_inst", inst_out, 32'd0);
        chk("rwa_pc", pc_out, 32'd0);
        @(negedge clk);
        chk("rwa_refetch", {31'd0, imem_req}, 32'd1);
        chk("rwa_addr", imem_addr, 32'd0);
        imem_ack = 1'b1;
        imem_rdata = 32'h0000_0020;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("ri_valid_pre", {31'd0, inst_valid}, 32'd1);
        // reset during ISSUE, colliding with ready
        reset = 1'b1;
        inst_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        inst_ready = 1'b0;
        chk("ri_valid", {31'd0, inst_valid}, 32'd0);
        chk("ri_inst", inst_out, 32'd0);
        chk("ri_req", {31'd0, imem_req}, 32'd0);
        chk("ri_pc", pc_out, 32'd0);
        @(negedge clk);
        chk("ri_refetch", {31'd0, imem_req}, 32'd1);
        chk("ri_addr", imem_addr, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
